// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory request/response channel,
// core-side instruction handshake and the branch/jump redirect port.
interface instruction_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            o_Mem_Req_Valid;
  logic            i_Mem_Req_Ready;
  logic [XLEN-1:0] o_Mem_Req_Addr;
  logic            i_Mem_Resp_Valid;
  logic [XLEN-1:0] i_Mem_Resp_Data;
  logic            o_Instruction_Valid;
  logic            i_Instruction_Ready;
  logic [XLEN-1:0] o_Instruction;
  logic [XLEN-1:0] o_Instruction_Addr;
  logic            i_Redirect_Valid;
  logic [XLEN-1:0] i_Redirect_Addr;

  // Fetch unit side
  modport master (
    output o_Mem_Req_Valid, o_Mem_Req_Addr,
    output o_Instruction_Valid, o_Instruction, o_Instruction_Addr,
    input  i_Mem_Req_Ready, i_Mem_Resp_Valid, i_Mem_Resp_Data,
    input  i_Instruction_Ready, i_Redirect_Valid, i_Redirect_Addr
  );

  // Memory / core / branch-unit side
  modport slave (
    input  o_Mem_Req_Valid, o_Mem_Req_Addr,
    input  o_Instruction_Valid, o_Instruction, o_Instruction_Addr,
    output i_Mem_Req_Ready, i_Mem_Resp_Valid, i_Mem_Resp_Data,
    output i_Instruction_Ready, i_Redirect_Valid, i_Redirect_Addr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Decoupled RV32 fetch stage.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | just out of reset, no requests issued; leaves after one cycle
//   S_FETCH | normal operation, every response is live
//   S_DRAIN | stale responses from before a redirect are still in flight
//
// Requests are credit limited: in-flight requests plus buffered words never
// exceed FIFO_DEPTH, so every live response always finds a free slot.
// Responses return in order, so after a redirect the first r_Drop responses
// are exactly the stale ones and can be discarded by count alone.
module instruction_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic                      i_Clock,
  input logic                      i_Reset_N,
  instruction_fetch_unit_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            req_valid, req_valid_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding, outstanding_nxt;
  logic [CW-1:0]   drop, drop_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_word [FIFO_DEPTH];

  logic            req_fire, resp_fire, redirect, push, pop;
  logic [XLEN-1:0] target;
  logic [SW-1:0]   credit;

  // Next-state and handshake decode for the coming edge
  always_comb begin
    req_fire        = req_valid & bus.i_Mem_Req_Ready;
    resp_fire       = bus.i_Mem_Resp_Valid;
    redirect        = bus.i_Redirect_Valid;
    // A pop in the redirect cycle is moot: the whole buffer is flushed.
    pop             = (count != '0) & bus.i_Instruction_Ready & ~redirect;
    target          = bus.i_Redirect_Addr & ~XLEN'(3);
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_fire);
    push            = 1'b0;
    drop_nxt        = drop;
    if (redirect) begin
      // Everything still in flight after this edge, including a request
      // firing right now, belongs to the old path.
      drop_nxt = outstanding_nxt;
    end else if (resp_fire) begin
      if (drop != '0) drop_nxt = drop - CW'(1);
      else            push     = 1'b1;
    end
    count_nxt = redirect ? '0 : (count + CW'(push) - CW'(pop));

    state_nxt = S_FETCH;
    if (state != S_IDLE && drop_nxt != '0) state_nxt = S_DRAIN;

    credit        = SW'(outstanding_nxt) + SW'(count_nxt);
    req_valid_nxt = (state_nxt != S_IDLE) && (credit < SW'(FIFO_DEPTH));
  end

  // Controller FSM, counters, PCs and instruction buffer
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state       <= S_IDLE;
      req_valid   <= 1'b0;
      fetch_pc    <= RESET_VECTOR & ~XLEN'(3);
      resp_pc     <= RESET_VECTOR & ~XLEN'(3);
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      req_valid   <= req_valid_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      count       <= count_nxt;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) begin
          fifo_pc[wr_ptr]   <= resp_pc;
          fifo_word[wr_ptr] <= bus.i_Mem_Resp_Data;
          wr_ptr            <= wr_ptr + PW'(1);
          resp_pc           <= resp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign bus.o_Mem_Req_Valid     = req_valid;
  assign bus.o_Mem_Req_Addr      = fetch_pc;
  assign bus.o_Instruction_Valid = (count != '0);
  assign bus.o_Instruction       = fifo_word[rd_ptr];
  assign bus.o_Instruction_Addr  = fifo_pc[rd_ptr];

endmodule
